// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding controller: select codes,
// register index width and the shadow pipeline stage entry.
package fwd_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } stage_t;

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage instruction info in, stall and EX-cycle mux selects out.
interface fwd_ctrl_if #(
  parameter int unsigned REG_ADDR_W = fwd_pkg::REG_ADDR_W
) ();

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    input  stall, fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
    output stall, fwd_sel_a, fwd_sel_b
  );

endinterface

// File: rtl/fwd_match.sv
// Compares one source register against the EX and MEM shadow entries and
// yields a mux select (EX wins) plus a load-in-EX hit flag.
module fwd_match
  import fwd_pkg::*;
#(
  parameter logic [REG_ADDR_W-1:0] ZERO_REG = '0
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  stage_t                ex_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_we_i,
  output logic [1:0]            sel_o,
  output logic                  ex_ld_hit_o
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;

  always_comb begin
    src_live    = (src_i != ZERO_REG);
    ex_hit      = src_live && ex_i.we && (ex_i.rd == src_i);
    mem_hit     = src_live && mem_we_i && (mem_rd_i == src_i);
    ex_ld_hit_o = ex_hit && ex_i.ld;
    if (ex_hit) begin
      sel_o = SEL_EXMEM;
    end else if (mem_hit) begin
      sel_o = SEL_MEMWB;
    end else begin
      sel_o = SEL_RF;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding-select and load-use stall generator with its own EX/MEM shadow
// of destination-register info; selects are registered for the EX cycle.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned           REG_ADDR_W = fwd_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = '0
) (
  input logic       clk,
  input logic       rst,
  fwd_ctrl_if.slave bus
);

  stage_t                ex_q, ex_d;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  mem_we_q;
  logic [1:0]            sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [1:0]            sel_a, sel_b;
  logic                  ld_hit_a, ld_hit_b;
  logic                  stall;
  logic                  accept;

  fwd_match #(.ZERO_REG(ZERO_REG)) u_match_a (
    .src_i      (bus.id_rs1),
    .ex_i       (ex_q),
    .mem_rd_i   (mem_rd_q),
    .mem_we_i   (mem_we_q),
    .sel_o      (sel_a),
    .ex_ld_hit_o(ld_hit_a)
  );

  fwd_match #(.ZERO_REG(ZERO_REG)) u_match_b (
    .src_i      (bus.id_rs2),
    .ex_i       (ex_q),
    .mem_rd_i   (mem_rd_q),
    .mem_we_i   (mem_we_q),
    .sel_o      (sel_b),
    .ex_ld_hit_o(ld_hit_b)
  );

  // Flush and reset both override the load-use stall; a rejected ID slot
  // enters EX as a bubble with selects forced to the register file.
  always_comb begin
    stall   = !rst && bus.id_valid && !bus.flush && (ld_hit_a || ld_hit_b);
    accept  = bus.id_valid && !bus.flush && !stall;
    ex_d    = '0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (accept) begin
      ex_d.rd = bus.id_rd;
      ex_d.we = bus.id_reg_write;
      ex_d.ld = bus.id_mem_read;
      sel_a_d = sel_a;
      sel_b_d = sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
    end else begin
      mem_rd_q <= ex_q.rd;
      mem_we_q <= ex_q.we;
      ex_q     <= ex_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_sel_a = sel_a_q;
  assign bus.fwd_sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: the stimulus side predicts stall and selects
// from a history of issued instructions; a monitor compares each cycle.
module tb_fwd_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_ctrl_if #(.REG_ADDR_W(5)) bus ();

  fwd_ctrl #(.REG_ADDR_W(5), .ZERO_REG(5'd0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          we;
    bit          ld;
    int unsigned rd;
  } op_t;

  typedef struct {
    int unsigned due;
    int unsigned kind;   // 0 stall, 1 sel_a, 2 sel_b
    int unsigned val;
  } exp_t;

  op_t         hist[$];   // issued slots, newest first: [0] now in EX, [1] in MEM
  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          last_stall = 0;
  int unsigned stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Distance-based rule: the most recent writer of src one slot back is
  // forwarded from EX/MEM, two slots back from MEM/WB.
  function automatic int unsigned sel_for(input int unsigned src);
    for (int d = 0; d < 2; d++) begin
      if (src != 0 && hist[d].we && hist[d].rd == src)
        return (d == 0) ? 1 : 2;
    end
    return 0;
  endfunction

  function automatic bit load_use(input int unsigned src);
    return src != 0 && hist[0].we && hist[0].ld && hist[0].rd == src;
  endfunction

  task automatic drive(input bit r, input bit v, input int unsigned rs1,
                       input int unsigned rs2, input int unsigned rd,
                       input bit we, input bit ld, input bit fl);
    bit          st;
    bit          acc;
    int unsigned ea, eb;
    op_t         o;
    exp_t        e;
    rst              = r;
    bus.id_valid     = v;
    bus.id_rs1       = rs1[4:0];
    bus.id_rs2       = rs2[4:0];
    bus.id_rd        = rd[4:0];
    bus.id_reg_write = we;
    bus.id_mem_read  = ld;
    bus.flush        = fl;
    st  = !r && v && !fl && (load_use(rs1) || load_use(rs2));
    acc = !r && v && !fl && !st;
    ea  = acc ? sel_for(rs1) : 0;
    eb  = acc ? sel_for(rs2) : 0;
    e.due = cyc;     e.kind = 0; e.val = st; sb.push_back(e);
    e.due = cyc + 1; e.kind = 1; e.val = ea; sb.push_back(e);
    e.due = cyc + 1; e.kind = 2; e.val = eb; sb.push_back(e);
    o.we = 0; o.ld = 0; o.rd = 0;
    if (r) begin
      hist.delete();
      hist.push_back(o);
      hist.push_back(o);
    end else begin
      if (acc) begin
        o.we = we; o.ld = ld; o.rd = rd;
      end
      hist.push_front(o);
      void'(hist.pop_back());
    end
    last_stall = st;
    if (st) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int unsigned rs1, input int unsigned rs2,
                     input int unsigned rd, input bit we, input bit ld);
    drive(0, 1, rs1, rs2, rd, we, ld, 0);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    int unsigned act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = bus.stall;
        1:       act = bus.fwd_sel_a;
        default: act = bus.fwd_sel_b;
      endcase
      checks++;
      if (e.due != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                 e.kind == 0 ? "stall" : (e.kind == 1 ? "fwd_sel_a" : "fwd_sel_b"),
                 cyc, act, e.val);
      end
    end
  end

  initial begin
    op_t   held;
    bit    r, v, fl;
    op_t   o;
    int unsigned rs1, rs2, hrs1, hrs2;
    rst = 1'b1;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.flush = 0;
    @(posedge clk);
    #1;

    // reset with random inputs, stall must stay low
    repeat (2) drive(1, 1, $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(1, 3), 1, 1, 0);
    ins(1, 2, 3, 1, 0);                       // first after reset: selects 0

    ins(0, 0, 5, 1, 0); ins(5, 6, 8, 1, 0);   // EX/MEM forward on A
    ins(0, 0, 5, 1, 0); nop(); ins(9, 5, 8, 1, 0);               // MEM/WB on B
    ins(0, 0, 5, 1, 0); ins(0, 0, 5, 1, 0); ins(5, 0, 8, 1, 0); // newest wins
    stall_cnt = 0;
    ins(0, 0, 7, 1, 1); ins(7, 7, 8, 1, 0); ins(7, 7, 8, 1, 0); nop(); nop();
    if (stall_cnt != 1) begin
      errors++;
      $display("FAIL load_use_stall_cycles got=%0d expected=1", stall_cnt);
    end
    checks++;
    ins(0, 0, 0, 1, 0); ins(0, 0, 8, 1, 0);   // writer of x0
    ins(0, 0, 3, 0, 0); ins(3, 3, 8, 1, 0);   // store-like rd=x3
    ins(0, 0, 7, 1, 1); drive(0, 1, 7, 0, 8, 1, 0, 1); ins(7, 7, 9, 1, 0);
    nop(); nop();

    // random traffic over a small register set so hazards are frequent
    held.we = 0; held.ld = 0; held.rd = 0; hrs1 = 0; hrs2 = 0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 99) < 10);
      v  = ($urandom_range(0, 99) < 85);
      if (last_stall) begin
        v = 1; o = held; rs1 = hrs1; rs2 = hrs2;
      end else begin
        rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3);
        o.rd = $urandom_range(0, 3);
        o.we = ($urandom_range(0, 9) < 8);
        o.ld = ($urandom_range(0, 9) < 4);
      end
      held = o; hrs1 = rs1; hrs2 = rs2;
      drive(r, v, rs1, rs2, o.rd, o.we, o.ld, fl);
    end
    nop(); nop();
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
